dp_ram_be_init: RTL
===================

// Module: dp_ram_be_init
// PURPOSE
//  Simple dual-port synchronous RAM (one write port, one read port, one clock): next
//  generation of the FIFO storage array. Adds per-byte write enables, selectable read
//  latency, selectable read-during-write result, and a sequential zero-init engine
//  (run after reset and on clr). The engine replaces the single-cycle array reset.
//  Sits under the FIFO/queue controllers as their backing store.
// PARAMETERS
//  ADDR_WIDTH  9   address bits; DEPTH = 2**ADDR_WIDTH words
//  DATA_WIDTH  32  word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
//  RD_LATENCY  1   1 = registered read; 2 = extra output register stage
//  RDW_MODE    0   same-address read+write in one cycle: 0 = old data, 1 = new (merged)
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           asynchronous, active-high reset
//  clr       in   1           synchronous request to re-zero the whole array
//  wr_en     in   1           write strobe
//  wr_addr   in   ADDR_WIDTH  write address
//  wr_be     in   NB          byte enables; bit b covers wr_data[8b+7:8b]
//  wr_data   in   DATA_WIDTH  write data
//  rd_en     in   1           read strobe
//  rd_addr   in   ADDR_WIDTH  read address
//  rd_data   out  DATA_WIDTH  read data; valid only while rd_valid = 1
//  rd_valid  out  1           rd_data carries the result of an accepted read
//  init_busy out  1           1 while the init engine owns the array
// BEHAVIOUR
//  - Reset (rst=1, async): rd_data=0, rd_valid=0, all read-pipeline valids=0,
//    init_busy=1, FSM=INIT, init_addr=0. Array contents undefined until INIT completes.
//  - FSM INIT: each cycle writes 0 to mem[init_addr] and increments init_addr. The cycle
//    that writes DEPTH-1 moves the FSM to READY. INIT lasts exactly DEPTH cycles after
//    rst deasserts. init_busy = (state==INIT), registered.
//  - FSM READY: clr=1 -> INIT with init_addr=0 next cycle. In INIT, clr=1 restarts from 0.
//  - Entering INIT, by reset or clr, flushes the read pipeline: rd_valid=0 next cycle.
//    Reads already in flight are dropped. rd_data is left unchanged.
//  - While in INIT, or in the cycle clr=1, wr_en and rd_en are ignored. Nothing is
//    written and no rd_valid is produced.
//  - Write (READY, wr_en=1, clr=0): for each b with wr_be[b]=1, the byte lane
//    mem[wr_addr][8b+7:8b] <= wr_data[8b+7:8b]. Other lanes keep their value.
//    wr_be=0 is a legal no-op.
//  - Read (READY, rd_en=1, clr=0) accepted in cycle N: rd_data and rd_valid=1 appear
//    after clock edge N+RD_LATENCY. Back-to-back reads give one result per cycle.
//  - rd_valid=0 cycles: rd_data holds its last value and does not toggle.
//  - Same-cycle read and write to the same address, both accepted:
//    RDW_MODE=0 -> the read returns the pre-write word.
//    RDW_MODE=1 -> the read returns the merge: wr_data on enabled lanes, old mem on the rest.
//  - Different addresses: fully independent. A read one cycle after a write to the same
//    address always sees the written data.
//  - Address wrap: none possible; every ADDR_WIDTH value is a valid word.
// TESTING  (ADDR_WIDTH=4, DATA_WIDTH=32 unless stated)
//  1. Release rst, hold rd_en=0 -> init_busy=1 for exactly 16 cycles, then 0.
//     Then read all 16 addresses -> every rd_data=0x0000_0000.
//  2. Write 0xAABBCCDD @3 with be=4'hF; then write 0x11223344 @3 with be=4'b0101;
//     then read @3 -> rd_data=0xAA22CC44, rd_valid 1 cycle after rd_en (RD_LATENCY=1).
//     With RD_LATENCY=2 -> the same data arrives 2 cycles after rd_en.
//  3. @5 holds 0x0; same cycle write 0xDEADBEEF, be=4'b0011 and read @5:
//     RDW_MODE=0 -> 0x00000000; RDW_MODE=1 -> 0x0000BEEF. Next read @5 -> 0x0000BEEF.
//  4. Stream reads @0..7 on consecutive cycles while writing @8..15 -> eight rd_valid
//     pulses in order, no gaps, data unaffected by the writes.
//  5. In READY with a read in flight, pulse clr -> rd_valid=0 next cycle, init_busy=1
//     for 16 cycles, writes during INIT discarded, then all addresses read 0.
//  6. Assert rst mid-INIT and mid-read -> rd_valid=0 and rd_data=0 immediately (async).
//     After release, INIT restarts at addr 0 and lasts the full 16 cycles.

Source files
------------

// File: rtl/dp_ram_be_init.sv
// dp_ram_be_init: simple dual-port synchronous RAM (one write port, one read
// port, single clock) with per-byte write enables, selectable read latency,
// selectable read-during-write behaviour and a sequential zero-init engine
// that runs after reset and on every clr request.
//
// Strobe semantics: wr_en and rd_en are single-cycle strobes with no
// back-pressure. A strobe is accepted only in a cycle where the engine is
// READY and clr is low; while init_busy is high (or clr is high) strobes are
// silently dropped. An accepted read produces exactly one rd_valid pulse
// RD_LATENCY clock edges later unless an init (reset or clr) intervenes.
module dp_ram_be_init #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [DATA_WIDTH/8-1:0]   wr_be,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      rd_en,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_valid,
   output logic                      init_busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   init_addr_q;
   logic [ADDR_WIDTH-1:0]   init_addr_d;
   logic                    init_busy_q;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_acc;
   logic                    rd_acc;
   logic                    flush;
   logic                    same_addr;
   logic [DATA_WIDTH-1:0]   wr_mask;
   logic [DATA_WIDTH-1:0]   old_word;
   logic [DATA_WIDTH-1:0]   merged_word;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    rd_valid_q;

   // ------------------------------------------------------------------
   // Init engine
   // ------------------------------------------------------------------

   // Next-state and init address: walk every word once, restart on clr.
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      case (state_q)
         ST_INIT: begin
            if (clr) begin
               init_addr_d = '0;
            end else begin
               init_addr_d = init_addr_q + ADDR_WIDTH'(1);
               if (&init_addr_q) begin
                  state_d = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (clr) begin
               state_d     = ST_INIT;
               init_addr_d = '0;
            end
         end
         default: begin
            state_d     = ST_INIT;
            init_addr_d = '0;
         end
      endcase
   end

   // State register; init_busy is registered from the next state so it
   // lines up exactly with the cycles the engine owns the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
         init_busy_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         init_busy_q <= (state_d == ST_INIT);
      end
   end

   assign init_busy = init_busy_q;

   // ------------------------------------------------------------------
   // Port acceptance
   // ------------------------------------------------------------------

   // User ports only act when the array is ours and no clr is pending.
   always_comb begin
      wr_acc = (state_q == ST_READY) && !clr && wr_en;
      rd_acc = (state_q == ST_READY) && !clr && rd_en;
      flush  = clr;
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------

   // Expand byte enables to a bit mask for the read-during-write merge.
   always_comb begin
      wr_mask = '0;
      for (int b = 0; b < NB; b++) begin
         wr_mask[8*b +: 8] = {8{wr_be[b]}};
      end
   end

   // Array write: the init engine has priority; otherwise per-lane writes.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem[init_addr_q] <= '0;
      end else if (wr_acc) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Read word selection: old contents, or the merged word when a write to
   // the same address lands in the same cycle and new-data mode is chosen.
   always_comb begin
      old_word    = mem[rd_addr];
      same_addr   = wr_acc && (wr_addr == rd_addr);
      merged_word = (old_word & ~wr_mask) | (wr_data & wr_mask);
      rd_word     = old_word;
      if ((RDW_MODE == 1) && same_addr) begin
         rd_word = merged_word;
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline
   // ------------------------------------------------------------------

   if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  s1_valid_q;

      // First stage: capture the array word; data only moves on a real read.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
         end else if (flush) begin
            s1_valid_q <= 1'b0;
         end else begin
            s1_valid_q <= rd_acc;
            if (rd_acc) begin
               s1_data_q <= rd_word;
            end
         end
      end

      // Output stage: rd_data holds its value between valid results.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
         end else if (flush) begin
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               rd_data_q <= s1_data_q;
            end
         end
      end
   end else begin : g_lat1
      // Single registered stage: rd_data holds its value between results.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
         end else if (flush) begin
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
               rd_data_q <= rd_word;
            end
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule
